// File: rtl/opcode_type_pkg.sv
// opcode_type: shared definitions for the multi-cycle RV32I control unit.
// Holds the FSM state enum, RV32I opcode constants, ALU / load / store-mask
// encodings and the registered control bundle produced by the decoder.
package opcode_type;

    // FETCH is encoded as zero so the forced-zero outputs during reset also
    // read back as FETCH on the state port.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    localparam logic [2:0] LD_LB   = 3'b000;
    localparam logic [2:0] LD_LH   = 3'b001;
    localparam logic [2:0] LD_LW   = 3'b010;
    localparam logic [2:0] LD_LBU  = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_NONE = 3'b111;

    localparam logic [3:0] BM_B = 4'b0001;
    localparam logic [3:0] BM_H = 4'b0011;
    localparam logic [3:0] BM_W = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_LD  = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic       insn_vld;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       is_jump;
        logic [2:0] br_f3;      // branch condition selector, kept for EXEC
        logic       br_un;
        logic       a_sel;
        logic       b_sel;
        logic [3:0] alu_sel;
        logic [2:0] ld_sel;
        logic [3:0] bmask;
        logic [1:0] wb_sel;
    } ctrl_t;

endpackage

// File: rtl/rv_decoder.sv
// rv_decoder: purely combinational RV32I decode.
// Ports: instr (32-bit instruction) -> ctrl (control bundle), insn_vld (legal).
module rv_decoder
    import opcode_type::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        insn_vld
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    // Register and immediate fields belong to the datapath, not to control.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl          = '0;
        ctrl.insn_vld = 1'b1;
        ctrl.br_f3    = f3;
        ctrl.br_un    = 1'b1;
        ctrl.b_sel    = 1'b1;
        ctrl.alu_sel  = ALU_ADD;
        ctrl.ld_sel   = LD_NONE;
        ctrl.bmask    = BM_W;
        ctrl.wb_sel   = WB_ALU;
        case (opc)
            OPC_LUI:   ctrl.alu_sel = ALU_PASSB;
            OPC_AUIPC: ctrl.a_sel = 1'b1;
            OPC_JAL: begin
                ctrl.a_sel   = 1'b1;
                ctrl.is_jump = 1'b1;
                ctrl.wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                ctrl.is_jump = 1'b1;
                ctrl.wb_sel  = WB_PC4;
            end
            OPC_BRANCH: begin
                // ALU forms the target pc+imm; comparator handles the condition.
                ctrl.is_branch = 1'b1;
                ctrl.a_sel     = 1'b1;
                ctrl.br_un     = ~f3[1];
                ctrl.insn_vld  = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_LOAD: begin
                ctrl.is_load = 1'b1;
                ctrl.wb_sel  = WB_LD;
                case (f3)
                    3'b000:  ctrl.ld_sel = LD_LB;
                    3'b001:  ctrl.ld_sel = LD_LH;
                    3'b010:  ctrl.ld_sel = LD_LW;
                    3'b100:  begin ctrl.ld_sel = LD_LBU; ctrl.br_un = 1'b0; end
                    3'b101:  begin ctrl.ld_sel = LD_LHU; ctrl.br_un = 1'b0; end
                    default: ctrl.insn_vld = 1'b0;
                endcase
            end
            OPC_STORE: begin
                ctrl.is_store = 1'b1;
                case (f3)
                    3'b000:  ctrl.bmask = BM_B;
                    3'b001:  ctrl.bmask = BM_H;
                    3'b010:  ctrl.bmask = BM_W;
                    default: ctrl.insn_vld = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                // Only srai carries an op modifier in funct7; other immediates
                // use those bits as immediate data.
                ctrl.alu_sel = {(f3 == 3'b101) && f7[5], f3};
                ctrl.br_un   = (f3 != 3'b011);
                if (f3 == 3'b001)
                    ctrl.insn_vld = (f7 == 7'h00);
                else if (f3 == 3'b101)
                    ctrl.insn_vld = (f7 == 7'h00) || (f7 == 7'h20);
            end
            OPC_OP: begin
                ctrl.b_sel    = 1'b0;
                ctrl.alu_sel  = {f7[5], f3};
                ctrl.br_un    = (f3 != 3'b011);
                ctrl.insn_vld = (f7 == 7'h00) ||
                                ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            default: ctrl.insn_vld = 1'b0;
        endcase
    end

    assign insn_vld = ctrl.insn_vld;

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control FSM.
// Inputs: clk, rst (sync, active high), instr, imem_ack, dmem_ack, br_less, br_equal.
// Outputs: fetch/memory/writeback strobes, registered control bundle
// (br_un, a_sel, b_sel, alu_sel, ld_sel, bmask, wb_sel, insn_vld),
// sticky illegal/timeout traps, retire pulse, instret counter, state.
module mc_control_unit
    import opcode_type::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             br_less,
    input  logic             br_equal,
    output logic             imem_req,
    output logic             ir_wr_en,
    output logic             pc_wr_en,
    output logic             pc_sel,
    output logic             reg_wr_en,
    output logic             br_un,
    output logic             a_sel,
    output logic             b_sel,
    output logic [3:0]       alu_sel,
    output logic             dmem_req,
    output logic             wr_en,
    output logic [2:0]       ld_sel,
    output logic [3:0]       bmask,
    output logic [1:0]       wb_sel,
    output logic             insn_vld,
    output logic             illegal,
    output logic             timeout,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    state_e           st_q, st_d;
    ctrl_t            dec, bnd_q;
    logic             dec_vld;
    logic [7:0]       wait_q;
    logic [CNT_W-1:0] instret_q;
    logic             ill_q, to_q;
    logic             taken, to_hit, waiting;
    logic             imem_c, irw_c, pcw_c, pcs_c, regw_c, dreq_c, wen_c, ret_c;

    rv_decoder u_dec (
        .instr    (instr),
        .ctrl     (dec),
        .insn_vld (dec_vld)
    );

    always_comb begin
        case (bnd_q.br_f3)
            3'b000:         taken = br_equal;
            3'b001:         taken = ~br_equal;
            3'b100, 3'b110: taken = br_less;
            3'b101, 3'b111: taken = ~br_less | br_equal;
            default:        taken = 1'b0;
        endcase
    end

    // wait_q counts cycles already spent waiting, so the last allowed cycle
    // is MEM_TIMEOUT-1; an ack in that cycle is checked first and wins.
    assign waiting = (st_q == S_FETCH) || (st_q == S_MEM);
    assign to_hit  = (wait_q == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        st_d   = st_q;
        imem_c = 1'b0;
        irw_c  = 1'b0;
        pcw_c  = 1'b0;
        pcs_c  = 1'b0;
        regw_c = 1'b0;
        dreq_c = 1'b0;
        wen_c  = 1'b0;
        ret_c  = 1'b0;
        case (st_q)
            S_FETCH: begin
                imem_c = 1'b1;
                if (imem_ack) begin
                    irw_c = 1'b1;
                    st_d  = S_DECODE;
                end else if (to_hit) begin
                    st_d = S_TRAP;
                end
            end
            S_DECODE: st_d = dec_vld ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (bnd_q.is_branch) begin
                    pcw_c = 1'b1;
                    pcs_c = taken;
                    ret_c = 1'b1;
                    st_d  = S_FETCH;
                end else if (bnd_q.is_load || bnd_q.is_store) begin
                    st_d = S_MEM;
                end else begin
                    st_d = S_WB;
                end
            end
            S_MEM: begin
                dreq_c = 1'b1;
                wen_c  = bnd_q.is_store;
                if (dmem_ack) begin
                    if (bnd_q.is_store) begin
                        pcw_c = 1'b1;
                        ret_c = 1'b1;
                        st_d  = S_FETCH;
                    end else begin
                        st_d = S_WB;
                    end
                end else if (to_hit) begin
                    st_d = S_TRAP;
                end
            end
            S_WB: begin
                regw_c = 1'b1;
                pcw_c  = 1'b1;
                pcs_c  = bnd_q.is_jump;
                ret_c  = 1'b1;
                st_d   = S_FETCH;
            end
            S_TRAP:  st_d = S_TRAP;
            default: st_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_FETCH;
            bnd_q     <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            ill_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == S_DECODE) begin
                bnd_q <= dec;
                if (!dec_vld) ill_q <= 1'b1;
            end
            if (st_d != st_q)
                wait_q <= '0;
            else if (waiting)
                wait_q <= wait_q + 8'd1;
            if (waiting && (st_d == S_TRAP)) to_q <= 1'b1;
            if (ret_c) instret_q <= instret_q + 1'b1;
        end
    end

    // Everything is forced low while rst is held, including mid-transaction.
    assign imem_req  = imem_c & ~rst;
    assign ir_wr_en  = irw_c  & ~rst;
    assign pc_wr_en  = pcw_c  & ~rst;
    assign pc_sel    = pcs_c  & ~rst;
    assign reg_wr_en = regw_c & ~rst;
    assign dmem_req  = dreq_c & ~rst;
    assign wr_en     = wen_c  & ~rst;
    assign retire    = ret_c  & ~rst;
    assign br_un     = bnd_q.br_un & ~rst;
    assign a_sel     = bnd_q.a_sel & ~rst;
    assign b_sel     = bnd_q.b_sel & ~rst;
    assign alu_sel   = rst ? 4'd0 : bnd_q.alu_sel;
    assign ld_sel    = rst ? 3'd0 : bnd_q.ld_sel;
    assign bmask     = rst ? 4'd0 : bnd_q.bmask;
    assign wb_sel    = rst ? 2'd0 : bnd_q.wb_sel;
    assign insn_vld  = bnd_q.insn_vld & ~rst & (st_q != S_TRAP);
    assign illegal   = ill_q & ~rst;
    assign timeout   = to_q & ~rst;
    assign instret   = rst ? '0 : instret_q;
    assign state     = rst ? 3'd0 : 3'(st_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed instruction vectors drive a
// transaction-level timing model that emits the expected per-cycle outputs
// into a queue; one compare process checks every cycle at the falling edge.
module tb_mc_control_unit;
    import opcode_type::*;

    localparam int MT = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] instr = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_less = 1'b0, br_equal = 1'b0;
    logic        imem_req, ir_wr_en, pc_wr_en, pc_sel, reg_wr_en, br_un, a_sel, b_sel;
    logic [3:0]  alu_sel, bmask;
    logic        dmem_req, wr_en, insn_vld, illegal, timeout, retire;
    logic [2:0]  ld_sel, state;
    logic [1:0]  wb_sel;
    logic [31:0] instret;

    always #5 clk = ~clk;

    mc_control_unit #(.CNT_W(32), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .br_less(br_less), .br_equal(br_equal), .imem_req(imem_req), .ir_wr_en(ir_wr_en),
        .pc_wr_en(pc_wr_en), .pc_sel(pc_sel), .reg_wr_en(reg_wr_en), .br_un(br_un),
        .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .dmem_req(dmem_req), .wr_en(wr_en),
        .ld_sel(ld_sel), .bmask(bmask), .wb_sel(wb_sel), .insn_vld(insn_vld),
        .illegal(illegal), .timeout(timeout), .retire(retire), .instret(instret), .state(state)
    );

    typedef enum int {K_ALU, K_JUMP, K_BR, K_LOAD, K_STORE, K_ILL} kind_e;

    typedef struct packed {
        logic       vld;
        logic [3:0] alu;
        logic       a, b, un;
        logic [2:0] ld;
        logic [3:0] bm;
        logic [1:0] wb;
    } bnd_t;

    typedef struct {
        logic [31:0] instr;
        kind_e       kind;
        int          fw, mw, rst_mem;
        logic        less, eq, taken;
        bnd_t        b;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic        imem, irw, pcw, pcs, regw, dreq, wen, ret, ill, to, vld, chkb;
        logic [31:0] cnt;
        bnd_t        b;
    } exp_t;

    exp_t        expq[$];
    int          n_chk = 0, n_err = 0, n_cyc = 0;
    logic [31:0] m_cnt = '0, pre_cnt = '0;
    logic        m_ill = 1'b0, m_to = 1'b0, pre_ill = 1'b0, pre_to = 1'b0;
    bnd_t        m_b = '0;
    logic [31:0] cur_instr = '0;
    logic        cur_less = 1'b0, cur_eq = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // strobe order: {imem_req, ir_wr_en, pc_wr_en, pc_sel, reg_wr_en, dmem_req, wr_en, retire}
    task automatic cyc(input logic [2:0] st, input logic ia, input logic da,
                       input logic [7:0] sb, input logic chkb);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b0; imem_ack = ia; dmem_ack = da;
        instr = cur_instr; br_less = cur_less; br_equal = cur_eq;
        e.st = st;
        {e.imem, e.irw, e.pcw, e.pcs, e.regw, e.dreq, e.wen, e.ret} = sb;
        e.ill = m_ill; e.to = m_to; e.cnt = m_cnt; e.chkb = chkb; e.b = m_b;
        e.vld = (st == S_TRAP) ? 1'b0 : m_b.vld;
        expq.push_back(e);
        n_cyc++;
        if (e.ret) m_cnt++;
    endtask

    // One reset cycle; DUT flags are captured just before rst goes high.
    task automatic rst_cyc();
        exp_t e;
        @(posedge clk); #1;
        pre_cnt = instret; pre_ill = illegal; pre_to = timeout;
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        e.st = '0;
        {e.imem, e.irw, e.pcw, e.pcs, e.regw, e.dreq, e.wen, e.ret} = '0;
        e.ill = 1'b0; e.to = 1'b0; e.vld = 1'b0; e.chkb = 1'b1; e.cnt = '0; e.b = '0;
        expq.push_back(e);
        m_cnt = '0; m_ill = 1'b0; m_to = 1'b0; m_b = '0;
    endtask

    task automatic trap_cycles();
        for (int k = 0; k < 3; k++) cyc(S_TRAP, 1'b1, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic run_insn(input vec_t v);
        logic ack, st;
        cur_instr = v.instr; cur_less = v.less; cur_eq = v.eq;
        n_cyc = 0;
        for (int i = 0; i < MT; i++) begin
            ack = (i == v.fw);
            cyc(S_FETCH, ack, 1'b0, {1'b1, ack, 6'b0}, 1'b1);
            if (ack) break;
        end
        if (v.fw >= MT) begin m_to = 1'b1; trap_cycles(); return; end
        cyc(S_DECODE, 1'b0, 1'b0, 8'h00, 1'b1);
        if (v.kind == K_ILL) begin m_ill = 1'b1; trap_cycles(); return; end
        m_b = v.b;
        if (v.kind == K_BR) begin
            cyc(S_EXEC, 1'b0, 1'b0, {2'b00, 1'b1, v.taken, 3'b000, 1'b1}, 1'b1);
            return;
        end
        cyc(S_EXEC, 1'b0, 1'b0, 8'h00, 1'b1);
        if (v.kind == K_LOAD || v.kind == K_STORE) begin
            st = (v.kind == K_STORE);
            for (int j = 0; j < MT; j++) begin
                if (v.rst_mem > 0 && j == v.rst_mem) begin rst_cyc(); return; end
                ack = (j == v.mw);
                cyc(S_MEM, 1'b0, ack, {2'b00, ack & st, 2'b00, 1'b1, st, ack & st}, 1'b1);
                if (ack) break;
            end
            if (v.mw >= MT) begin m_to = 1'b1; trap_cycles(); return; end
            if (st) return;
        end
        cyc(S_WB, 1'b0, 1'b0, {2'b00, 1'b1, (v.kind == K_JUMP), 1'b1, 2'b00, 1'b1}, 1'b1);
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input kind_e k, input int fw, input int mw,
                                input logic less, input logic eq, input logic taken,
                                input logic [3:0] alu, input logic a, input logic b, input logic un,
                                input logic [2:0] ld, input logic [3:0] bm, input logic [1:0] wb);
        vec_t v;
        v.instr = ins; v.kind = k; v.fw = fw; v.mw = mw; v.rst_mem = 0;
        v.less = less; v.eq = eq; v.taken = taken;
        v.b = {1'b1, alu, a, b, un, ld, bm, wb};
        return v;
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("state", state, e.st);
            chk("imem_req", imem_req, e.imem);
            chk("ir_wr_en", ir_wr_en, e.irw);
            chk("pc_wr_en", pc_wr_en, e.pcw);
            chk("pc_sel", pc_sel, e.pcs);
            chk("reg_wr_en", reg_wr_en, e.regw);
            chk("dmem_req", dmem_req, e.dreq);
            chk("wr_en", wr_en, e.wen);
            chk("retire", retire, e.ret);
            chk("instret", instret, e.cnt);
            chk("illegal", illegal, e.ill);
            chk("timeout", timeout, e.to);
            chk("insn_vld", insn_vld, e.vld);
            if (e.chkb) begin
                chk("alu_sel", alu_sel, e.b.alu);
                chk("a_sel", a_sel, e.b.a);
                chk("b_sel", b_sel, e.b.b);
                chk("br_un", br_un, e.b.un);
                chk("ld_sel", ld_sel, e.b.ld);
                chk("bmask", bmask, e.b.bm);
                chk("wb_sel", wb_sel, e.b.wb);
            end
        end
    end

    vec_t lst[$];
    vec_t v;

    initial begin
        rst_cyc();
        rst_cyc();

        // ADDI x1,x0,5 with same-cycle fetch ack
        run_insn(mk(32'h00500093, K_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b111, 4'b1111, 2'b00));
        chk("lit_addi_cycles", n_cyc, 4);
        rst_cyc();
        chk("lit_addi_instret", pre_cnt, 1);

        // SB x0,0(x0) with dmem_ack three cycles late
        run_insn(mk(32'h00000023, K_STORE, 0, 3, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b111, 4'b0001, 2'b00));
        chk("lit_sb_cycles", n_cyc, 7);

        lst.push_back(mk(32'h00000463, K_BR,   0, 0, 0, 1, 1, 4'b0000, 1, 1, 1, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h00000463, K_BR,   1, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h00006463, K_BR,   0, 0, 1, 0, 1, 4'b0000, 1, 1, 0, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h00005463, K_BR,   0, 0, 1, 0, 0, 4'b0000, 1, 1, 1, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h00005463, K_BR,   0, 0, 1, 1, 1, 4'b0000, 1, 1, 1, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h00002083, K_LOAD, 2, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b010, 4'b1111, 2'b01));
        lst.push_back(mk(32'h00004083, K_LOAD, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 3'b011, 4'b1111, 2'b01));
        lst.push_back(mk(32'h402081B3, K_ALU,  0, 0, 0, 0, 0, 4'b1000, 0, 0, 1, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h4030D093, K_ALU,  0, 0, 0, 0, 0, 4'b1101, 0, 1, 1, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h123450B7, K_ALU,  0, 0, 0, 0, 0, 4'b1011, 0, 1, 1, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h000000EF, K_JUMP, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 3'b111, 4'b1111, 2'b10));
        lst.push_back(mk(32'h00008067, K_JUMP, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b111, 4'b1111, 2'b10));
        lst.push_back(mk(32'h003130B3, K_ALU,  0, 0, 0, 0, 0, 4'b0011, 0, 0, 0, 3'b111, 4'b1111, 2'b00));
        lst.push_back(mk(32'h00001097, K_ALU,  0, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 3'b111, 4'b1111, 2'b00));
        // fetch ack in the last allowed cycle still decodes
        lst.push_back(mk(32'h00500093, K_ALU,  3, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b111, 4'b1111, 2'b00));
        foreach (lst[i]) run_insn(lst[i]);
        rst_cyc();
        chk("lit_seq_instret", pre_cnt, 16);

        // illegal encodings
        run_insn(mk(32'hFFFFFFFF, K_ILL, 0, 0, 0, 0, 0, '0, 0, 0, 0, '0, '0, '0));
        rst_cyc();
        chk("lit_ill_ffff", pre_ill, 1);
        chk("lit_ill_no_to", pre_to, 0);
        run_insn(mk(32'h40001033, K_ILL, 0, 0, 0, 0, 0, '0, 0, 0, 0, '0, '0, '0));
        rst_cyc();
        run_insn(mk(32'h00002063, K_ILL, 0, 0, 0, 0, 0, '0, 0, 0, 0, '0, '0, '0));
        rst_cyc();

        // fetch timeout: no ack for MT cycles
        run_insn(mk(32'h00500093, K_ALU, 4, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b111, 4'b1111, 2'b00));
        rst_cyc();
        chk("lit_fetch_to", pre_to, 1);

        // data memory timeout on LW
        run_insn(mk(32'h00002083, K_LOAD, 0, 4, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b010, 4'b1111, 2'b01));
        rst_cyc();
        chk("lit_mem_to", pre_to, 1);

        // reset in the middle of a LW memory wait, then recover
        v = mk(32'h00002083, K_LOAD, 0, 3, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b010, 4'b1111, 2'b01);
        v.rst_mem = 2;
        run_insn(v);
        run_insn(mk(32'h00500093, K_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 3'b111, 4'b1111, 2'b00));
        rst_cyc();
        chk("lit_post_rst_instret", pre_cnt, 1);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
